// File: rtl/uart_pkg.sv
// uart_pkg: constants shared by the UART transmitter and receiver, and the transmitter FSM state type.
// Contents: UART_DATA_BITS, line levels for start/stop/idle, tx_state_t.
// Macro: UART_TX_PARITY_EN adds the PARITY state to tx_state_t.
package uart_pkg;
   localparam int   UART_DATA_BITS   = 8;
   localparam logic UART_START_LEVEL = 1'b0;
   localparam logic UART_STOP_LEVEL  = 1'b1;
   localparam logic UART_IDLE_LEVEL  = 1'b1;
   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_TX_PARITY_EN
      PARITY,
`endif
      STOP
   } tx_state_t;
endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: byte-write handshake and serial line status of the UART transmitter.
// Signals: i_TX_DV / i_TX_Byte (producer to transmitter),
//          o_TX_Ready, o_TX_Serial, o_TX_Active, o_TX_Done (transmitter to producer/line).
// Modports: master (producer side), slave (transmitter side).
interface uart_tx_if;
   logic       i_TX_DV;
   logic [7:0] i_TX_Byte;
   logic       o_TX_Ready;
   logic       o_TX_Serial;
   logic       o_TX_Active;
   logic       o_TX_Done;
   modport master (output i_TX_DV, i_TX_Byte, input o_TX_Ready, o_TX_Serial, o_TX_Active, o_TX_Done);
   modport slave  (input i_TX_DV, i_TX_Byte, output o_TX_Ready, o_TX_Serial, o_TX_Active, o_TX_Done);
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous FIFO buffering bytes between producer and serialiser.
// Ports: i_Clock, i_Reset_n (sync, active-low), i_Push/i_Data (write, ignored when full),
//        i_Pop (read, ignored when empty), o_Data (head, combinational), o_Full, o_Empty, o_Count.
// DEPTH must be a power of two so the pointers wrap naturally.
module uart_tx_fifo #(
   parameter  int DEPTH = 4,
   parameter  int WIDTH = 8,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             i_Clock,
   input  logic             i_Reset_n,
   input  logic             i_Push,
   input  logic [WIDTH-1:0] i_Data,
   input  logic             i_Pop,
   output logic [WIDTH-1:0] o_Data,
   output logic             o_Full,
   output logic             o_Empty,
   output logic [AW:0]      o_Count
);
   logic [WIDTH-1:0] r_Mem [DEPTH];
   logic [AW-1:0]    r_Wr, r_Rd;
   logic [AW:0]      r_Count;
   logic             w_Push, w_Pop;
   assign o_Full  = r_Count == (AW+1)'(DEPTH);
   assign o_Empty = r_Count == '0;
   assign o_Count = r_Count;
   assign o_Data  = r_Mem[r_Rd];
   // fullness is judged on the registered count, so a same-cycle pop never frees room for a push
   assign w_Push  = i_Push && !o_Full;
   assign w_Pop   = i_Pop && !o_Empty;
   always_ff @(posedge i_Clock)
      if (w_Push && i_Reset_n) r_Mem[r_Wr] <= i_Data;
   always_ff @(posedge i_Clock) begin
      if (!i_Reset_n) begin
         r_Wr    <= '0;
         r_Rd    <= '0;
         r_Count <= '0;
      end else begin
         r_Wr    <= r_Wr + AW'(w_Push);
         r_Rd    <= r_Rd + AW'(w_Pop);
         r_Count <= r_Count + (AW+1)'(w_Push) - (AW+1)'(w_Pop);
      end
   end
endmodule

// File: rtl/uart_tx.sv
// uart_tx: FIFO-fed UART transmitter, 1 start bit, 8 data bits LSB first, optional even parity, 1 stop bit.
// Ports: i_Clock, i_Reset_n (sync, active-low), bus (uart_tx_if.slave):
//        i_TX_DV/i_TX_Byte write, o_TX_Ready (FIFO not full), o_TX_Serial (idle high),
//        o_TX_Active (frame on line), o_TX_Done (last cycle of stop bit).
// Macro: UART_TX_PARITY_EN inserts an even-parity bit between data and stop.
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 217,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic     i_Clock,
   input  logic     i_Reset_n,
   uart_tx_if.slave bus
);
   localparam int            CW       = $clog2(CLKS_PER_BIT);
   localparam int            BW       = $clog2(UART_DATA_BITS);
   localparam int            AW       = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0] LAST     = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] DONE_AT  = CW'(CLKS_PER_BIT - 2);
   localparam logic [BW-1:0] LAST_BIT = BW'(UART_DATA_BITS - 1);
   tx_state_t                 r_State;
   logic [CW-1:0]             r_Cnt;
   logic [BW-1:0]             r_Bit;
   logic [UART_DATA_BITS-1:0] r_Shift;
   logic                      r_Serial, r_Active, r_Done;
   logic [UART_DATA_BITS-1:0] w_Head;
   logic [AW:0]               w_Count;
   logic                      w_Full, w_Empty, w_Last, w_Pop;
   uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(UART_DATA_BITS)) u_fifo (
      .i_Clock  (i_Clock),
      .i_Reset_n(i_Reset_n),
      .i_Push   (bus.i_TX_DV && !w_Full),
      .i_Data   (bus.i_TX_Byte),
      .i_Pop    (w_Pop),
      .o_Data   (w_Head),
      .o_Full   (w_Full),
      .o_Empty  (w_Empty),
      .o_Count  (w_Count)
   );
   assign w_Last          = r_Cnt == LAST;
   // the next byte is taken either from idle or straight out of the last stop cycle, so frames abut
   assign w_Pop           = !w_Empty && (r_State == IDLE || (r_State == STOP && w_Last));
   assign bus.o_TX_Ready  = w_Count != (AW+1)'(FIFO_DEPTH);
   assign bus.o_TX_Serial = r_Serial;
   assign bus.o_TX_Active = r_Active;
   assign bus.o_TX_Done   = r_Done;
   always_ff @(posedge i_Clock) begin
      if (!i_Reset_n) begin
         r_State  <= IDLE;
         r_Cnt    <= '0;
         r_Bit    <= '0;
         r_Shift  <= '0;
         r_Serial <= UART_IDLE_LEVEL;
         r_Active <= 1'b0;
         r_Done   <= 1'b0;
      end else begin
         // registered one cycle early so the pulse lands in the final stop cycle
         r_Done <= (r_State == STOP) && (r_Cnt == DONE_AT);
         r_Cnt  <= (r_State == IDLE || w_Last) ? '0 : r_Cnt + 1'b1;
         if (w_Pop) begin
            r_State  <= START;
            r_Shift  <= w_Head;
            r_Bit    <= '0;
            r_Serial <= UART_START_LEVEL;
            r_Active <= 1'b1;
         end else begin
            case (r_State)
               START: if (w_Last) begin
                  r_State  <= DATA;
                  r_Serial <= r_Shift[0];
               end
               DATA: if (w_Last) begin
                  if (r_Bit == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                     r_State  <= PARITY;
                     r_Serial <= ^r_Shift;
`else
                     r_State  <= STOP;
                     r_Serial <= UART_STOP_LEVEL;
`endif
                  end else begin
                     r_Bit    <= r_Bit + 1'b1;
                     r_Serial <= r_Shift[r_Bit + 1'b1];
                  end
               end
`ifdef UART_TX_PARITY_EN
               PARITY: if (w_Last) begin
                  r_State  <= STOP;
                  r_Serial <= UART_STOP_LEVEL;
               end
`endif
               STOP: if (w_Last) begin
                  r_State  <= IDLE;
                  r_Serial <= UART_IDLE_LEVEL;
                  r_Active <= 1'b0;
               end
               default: begin
                  r_State  <= IDLE;
                  r_Serial <= UART_IDLE_LEVEL;
                  r_Active <= 1'b0;
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx with CLKS_PER_BIT = 4, FIFO_DEPTH = 4.
// Stimulus pushes hand-computed {parity, byte} entries; a line monitor decodes each frame and pops/compares.
// Macro: UART_TX_PARITY_EN switches the expected frame to 11 bit-times with a checked parity bit.
module tb_uart_tx;
   localparam int CPB   = 4;
   localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   localparam int FL = NB * CPB;
   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   int         n_chk = 0;
   int         n_pass = 0;
   logic [8:0] exp_q[$];
   int         frames_seen = 0;
   int         done_seen = 0;
   int         b2b = 0;
   uart_tx_if bus();
   uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .i_Clock  (clk),
      .i_Reset_n(rst_n),
      .bus      (bus)
   );
   always #5 clk = ~clk;
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
   endtask
   // monitor: samples the line on every falling edge
   logic [FL-1:0] m_line, m_act, m_dn;
   task automatic check_frame();
      logic [8:0] e;
      logic [8:0] got;
      logic       shape_ok;
      int         nd, na;
      shape_ok = 1'b1;
      nd = 0;
      na = 0;
      got = '0;
      for (int b = 0; b < NB; b++)
         for (int j = 1; j < CPB; j++)
            if (m_line[b*CPB+j] !== m_line[b*CPB]) shape_ok = 1'b0;
      for (int i = 0; i < FL; i++) begin
         if (m_dn[i]) nd++;
         if (m_act[i]) na++;
      end
      for (int i = 0; i < 8; i++) got[i] = m_line[(i+1)*CPB];
`ifdef UART_TX_PARITY_EN
      got[8] = m_line[9*CPB];
`endif
      check("bit_shape", 32'(shape_ok), 1);
      check("stop_bit", 32'(m_line[(NB-1)*CPB]), 1);
      check("active_len", na, FL);
      check("done_count", nd, 1);
      check("done_last", 32'(m_dn[FL-1]), 1);
      if (exp_q.size() == 0) begin
         n_chk++;
         $display("FAIL unexpected_frame: got %0h, expected no frame at %0t", got[7:0], $time);
      end else begin
         e = exp_q.pop_front();
         check("frame_byte", 32'(got[7:0]), 32'(e[7:0]));
`ifdef UART_TX_PARITY_EN
         check("parity_bit", 32'(got[8]), 32'(e[8]));
`endif
      end
   endtask
   initial begin : monitor
      logic mon_in;
      int   k, cyc, last_end;
      mon_in = 1'b0;
      k = 0;
      cyc = 0;
      last_end = -10;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) mon_in = 1'b0;
         else begin
            if (bus.o_TX_Done) done_seen++;
            if (!mon_in && !bus.o_TX_Serial) begin
               mon_in = 1'b1;
               k = 0;
               if (last_end == cyc - 1) b2b++;
            end
            if (mon_in) begin
               m_line[k] = bus.o_TX_Serial;
               m_act[k]  = bus.o_TX_Active;
               m_dn[k]   = bus.o_TX_Done;
               k++;
               if (k == FL) begin
                  mon_in = 1'b0;
                  last_end = cyc;
                  frames_seen++;
                  check_frame();
               end
            end else begin
               check("idle_active", 32'(bus.o_TX_Active), 0);
               check("idle_done", 32'(bus.o_TX_Done), 0);
            end
         end
      end
   end
   task automatic tick();
      @(posedge clk);
      #2;
   endtask
   // drive one write for one cycle; accept is the hand-predicted o_TX_Ready at this edge
   task automatic write_byte(input logic [7:0] b, input logic p, input logic accept);
      check("ready_at_write", 32'(bus.o_TX_Ready), 32'(accept));
      bus.i_TX_DV = 1'b1;
      bus.i_TX_Byte = b;
      if (accept) exp_q.push_back({p, b});
      tick();
      bus.i_TX_DV = 1'b0;
   endtask
   task automatic wait_frames(input int target, input int budget);
      int n;
      n = 0;
      while (frames_seen < target && n < budget) begin
         tick();
         n++;
      end
      check("frame_timeout", 32'(frames_seen >= target), 1);
   endtask
   initial begin : stim
      int fr0, d0, b0;
      bus.i_TX_DV = 1'b0;
      bus.i_TX_Byte = 8'h00;
      repeat (3) tick();
      check("rst_serial", 32'(bus.o_TX_Serial), 1);
      check("rst_active", 32'(bus.o_TX_Active), 0);
      check("rst_done", 32'(bus.o_TX_Done), 0);
      check("rst_ready", 32'(bus.o_TX_Ready), 1);
      rst_n = 1'b1;
      for (int i = 0; i < 50; i++) begin
         tick();
         check("idle_serial", 32'(bus.o_TX_Serial), 1);
         check("idle_ready", 32'(bus.o_TX_Ready), 1);
         check("idle_act", 32'(bus.o_TX_Active), 0);
      end
      // single frame 0xA5 and first-byte latency
      write_byte(8'hA5, 1'b0, 1'b1);
      check("lat_pre", 32'(bus.o_TX_Serial), 1);
      tick();
      check("lat_start", 32'(bus.o_TX_Serial), 0);
      check("lat_active", 32'(bus.o_TX_Active), 1);
      wait_frames(1, 100);
      repeat (5) tick();
      // back-to-back frames
      fr0 = frames_seen;
      b0 = b2b;
      write_byte(8'h00, 1'b0, 1'b1);
      write_byte(8'hFF, 1'b0, 1'b1);
      write_byte(8'h55, 1'b0, 1'b1);
      wait_frames(fr0 + 3, 300);
      check("no_gap", b2b - b0, 2);
      repeat (5) tick();
      // overfill: byte 1 leaves at once, 2..5 fill the FIFO, 6 is refused
      fr0 = frames_seen;
      write_byte(8'h01, 1'b1, 1'b1);
      write_byte(8'h02, 1'b1, 1'b1);
      write_byte(8'h03, 1'b0, 1'b1);
      write_byte(8'h04, 1'b1, 1'b1);
      write_byte(8'h05, 1'b0, 1'b1);
      write_byte(8'h06, 1'b0, 1'b0);
      wait_frames(fr0 + 5, 400);
      repeat (5) tick();
      // reset in the middle of the data bits of 0x3C with two bytes queued
      fr0 = frames_seen;
      write_byte(8'h3C, 1'b0, 1'b1);
      write_byte(8'h11, 1'b0, 1'b1);
      write_byte(8'h22, 1'b0, 1'b1);
      repeat (8) tick();
      check("mid_data_active", 32'(bus.o_TX_Active), 1);
      d0 = done_seen;
      rst_n = 1'b0;
      exp_q.delete();
      tick();
      rst_n = 1'b1;
      check("abort_serial", 32'(bus.o_TX_Serial), 1);
      check("abort_ready", 32'(bus.o_TX_Ready), 1);
      check("abort_active", 32'(bus.o_TX_Active), 0);
      check("abort_done", 32'(bus.o_TX_Done), 0);
      for (int i = 0; i < 100; i++) begin
         tick();
         check("post_abort_line", 32'(bus.o_TX_Serial), 1);
      end
      check("post_abort_frames", frames_seen, fr0);
      check("post_abort_done", done_seen, d0);
      // parity values: 0x07 has odd weight, 0x03 even
      fr0 = frames_seen;
      write_byte(8'h07, 1'b1, 1'b1);
      wait_frames(fr0 + 1, 100);
      repeat (3) tick();
      write_byte(8'h03, 1'b0, 1'b1);
      wait_frames(fr0 + 2, 100);
      repeat (5) tick();
      check("queue_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
